// File: rtl/mips_mc_core_if.sv
// mips_mc_core_if: req/ready word-addressed memory bus between the core (master) and a unified memory (slave)
// Signals: mem_req/mem_we/mem_addr/mem_wdata from master; mem_rdata/mem_ready from slave.
interface mips_mc_core_if #(
  parameter int DW = 21,
  parameter int AW = 19
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle FETCH/DECODE/EXEC/MEM/WB core sharing one req/ready memory for code and data
// Ports: clock, reset (async, active-low), bus (memory master), PC/instr/destRegData debug outputs, halted.
module mips_mc_core #(
  parameter int             DW       = 21,
  parameter int             AW       = 19,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  mips_mc_core_if.master bus,
  output logic [AW-1:0] PC,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] destRegData,
  output logic          halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t        state;
  logic [DW-1:0] rf [8];
  logic [DW-1:0] a, b, alu_out, mdr, sext, r_res, alu, wdata;
  logic [4:0]    op;
  logic [2:0]    rs, rt, rd, funct, dst;
  logic [AW-1:0] target;
  logic          taken, done, is_mem, is_alu;
  always_comb begin
    op     = instr[DW-1:DW-5];
    rs     = instr[DW-6:DW-8];
    rt     = instr[DW-9:DW-11];
    rd     = instr[DW-12:DW-14];
    funct  = instr[2:0];
    sext   = {{11{instr[DW-12]}}, instr[DW-12:0]};
    r_res  = funct == 3'd0 ? a + b :
             funct == 3'd1 ? a - b :
             funct == 3'd2 ? a & b :
             funct == 3'd3 ? a | b :
             funct == 3'd4 ? {{(DW-1){1'b0}}, $signed(a) < $signed(b)} :
             funct == 3'd5 ? a ^ b : '0;
    alu    = op == 5'd0 ? r_res : a + sext;
    taken  = (op == 5'd4 && a == b) || (op == 5'd5 && a != b);
    // PC already holds PC+1 here, so the branch offset is added directly
    target = op == 5'd6 ? AW'(instr[DW-6:0]) : taken ? PC + sext[AW-1:0] : PC;
    is_mem = op == 5'd2 || op == 5'd3;
    is_alu = op == 5'd0 || op == 5'd1;
    dst    = op == 5'd0 ? rd : rt;
    wdata  = op == 5'd2 ? mdr : alu_out;
    done   = bus.mem_req && bus.mem_ready;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= FETCH;
      PC            <= RESET_PC;
      instr         <= '0;
      destRegData   <= '0;
      halted        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      a             <= '0;
      b             <= '0;
      alu_out       <= '0;
      mdr           <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          // the first cycle after reset only raises the request
          if (done) begin
            instr       <= bus.mem_rdata;
            PC          <= PC + AW'(1);
            bus.mem_req <= 1'b0;
            state       <= DECODE;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= PC;
          end
        end
        DECODE: begin
          a     <= rf[rs];
          b     <= rf[rt];
          state <= EXEC;
        end
        EXEC: begin
          alu_out       <= alu;
          PC            <= target;
          halted        <= op == 5'd31;
          state         <= op == 5'd31 ? HALT : is_alu ? WB : is_mem ? MEM : FETCH;
          bus.mem_req   <= op != 5'd31 && !is_alu;
          bus.mem_we    <= op == 5'd3;
          bus.mem_addr  <= is_mem ? alu[AW-1:0] : target;
          bus.mem_wdata <= b;
        end
        MEM: begin
          // a store goes straight back to FETCH, so the next fetch request is raised here
          if (done) begin
            mdr          <= bus.mem_rdata;
            bus.mem_req  <= op == 5'd3;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= PC;
            state        <= op == 5'd3 ? FETCH : WB;
          end
        end
        WB: begin
          destRegData  <= wdata;
          if (dst != 3'd0) rf[dst] <= wdata;
          bus.mem_req  <= 1'b1;
          bus.mem_we   <= 1'b0;
          bus.mem_addr <= PC;
          state        <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: directed programs against a small word memory with configurable ready latency
module tb_mips_mc_core;
  localparam int DW = 21;
  localparam int AW = 19;
  localparam logic [DW-1:0] HALT_I = {5'd31, 16'd0};
  localparam logic [DW-1:0] NOP_I  = {5'd7, 16'd0};
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr, dest;
  logic halted;
  int n_cmp = 0;
  int n_err = 0;
  mips_mc_core_if #(.DW(DW), .AW(AW)) bus ();
  mips_mc_core #(.DW(DW), .AW(AW), .RESET_PC('0)) dut (
    .clock(clock), .reset(reset), .bus(bus.master),
    .PC(pc), .instr(instr), .destRegData(dest), .halted(halted)
  );
  always #5 clock = ~clock;
  logic [DW-1:0] mem [64];
  int wait_n = 0;
  int wcnt = 0;
  logic ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
  assign bus.mem_ready = wait_n == 0 || (bus.mem_req && wcnt == wait_n);
  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_req && bus.mem_ready && bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    wcnt <= (!bus.mem_req || bus.mem_ready) ? 0 : wcnt + 1;
  end
  logic mon_en = 1'b0;
  int run = 0, acc = 0, min_len = 999, max_len = 0, viol = 0;
  logic [AW-1:0] p_addr;
  logic p_we;
  logic [DW-1:0] p_wdata;
  always @(negedge clock) begin
    if (mon_en && bus.mem_req) begin
      if (run > 0 && (bus.mem_addr != p_addr || bus.mem_we != p_we || bus.mem_wdata != p_wdata)) viol++;
      p_addr = bus.mem_addr;
      p_we = bus.mem_we;
      p_wdata = bus.mem_wdata;
      run++;
      if (bus.mem_ready) begin
        acc++;
        if (run < min_len) min_len = run;
        if (run > max_len) max_len = run;
        run = 0;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic load(input int a, input logic [DW-1:0] d);
    ld_en = 1'b1;
    ld_addr = 6'(a);
    ld_data = d;
    @(posedge clock);
    #1;
    ld_en = 1'b0;
  endtask
  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask
  task automatic wait_halt(input string tag, input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 32'(halted), 1);
  endtask
  function automatic logic [DW-1:0] ei(input int op, input int rs, input int rt, input int imm);
    return {5'(op), 3'(rs), 3'(rt), 10'(imm)};
  endfunction
  function automatic logic [DW-1:0] er(input int rs, input int rt, input int rd, input int f);
    return {5'd0, 3'(rs), 3'(rt), 3'(rd), 4'd0, 3'(f)};
  endfunction
  function automatic logic [DW-1:0] ej(input int a);
    return {5'd6, 16'(a)};
  endfunction
  initial begin
    int k;
    step(2);
    load(0, ei(1, 0, 1, 5));
    load(1, ei(1, 0, 2, -3));
    load(2, er(1, 2, 3, 0));
    load(3, HALT_I);
    check("rst_pc", 32'(pc), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_dest", 32'(dest), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_req", 32'(bus.mem_req), 0);
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_addr", 32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    release_reset();
    step(1);
    check("t1_first_req", 32'(bus.mem_req), 1);
    check("t1_first_addr", 32'(bus.mem_addr), 0);
    step(4);
    check("t1_addi_5", 32'(dest), 32'h5);
    step(4);
    check("t1_addi_m3", 32'(dest), 32'h1FFFFD);
    step(4);
    check("t1_add", 32'(dest), 32'h2);
    step(2);
    check("t1_not_halted", 32'(halted), 0);
    step(1);
    check("t1_halted", 32'(halted), 1);
    check("t1_pc", 32'(pc), 4);
    check("t1_halt_ir", 32'(instr), 32'(HALT_I));
    step(3);
    check("t1_halt_hold", 32'(halted), 1);
    check("t1_halt_noreq", 32'(bus.mem_req), 0);
    reset = 1'b0;
    wait_n = 2;
    load(0, ei(1, 0, 1, 5));
    load(1, ei(3, 0, 1, 10));
    load(2, ei(2, 0, 4, 10));
    load(3, er(4, 0, 5, 0));
    load(4, HALT_I);
    load(10, '0);
    run = 0; acc = 0; min_len = 999; max_len = 0; viol = 0;
    mon_en = 1'b1;
    release_reset();
    wait_halt("t2_halt", 300);
    mon_en = 1'b0;
    check("t2_mem10", 32'(mem[10]), 5);
    check("t2_r4_via_add", 32'(dest), 5);
    check("t2_accesses", 32'(acc), 7);
    check("t2_min_hold", 32'(min_len), 3);
    check("t2_max_hold", 32'(max_len), 3);
    check("t2_stable", 32'(viol), 0);
    reset = 1'b0;
    wait_n = 0;
    load(0, ei(4, 1, 1, 2));
    load(3, ei(5, 1, 1, 2));
    load(4, ej(7));
    load(7, HALT_I);
    release_reset();
    step(2);
    check("t3_pc_plus1", 32'(pc), 1);
    step(2);
    check("t3_beq_pc", 32'(pc), 3);
    check("t3_beq_addr", 32'(bus.mem_addr), 3);
    check("t3_beq_req", 32'(bus.mem_req), 1);
    step(3);
    check("t3_bne_pc", 32'(pc), 4);
    step(1);
    check("t3_j_fetch_pc", 32'(pc), 5);
    step(2);
    check("t3_j_pc", 32'(pc), 7);
    wait_halt("t3_halt", 20);
    reset = 1'b0;
    load(0, ei(4, 0, 0, -2));
    load(63, NOP_I);
    release_reset();
    step(4);
    check("t4_pc_max", 32'(pc), 32'h7FFFF);
    check("t4_addr_max", 32'(bus.mem_addr), 32'h7FFFF);
    step(1);
    check("t4_pc_wrap", 32'(pc), 0);
    check("t4_nop_ir", 32'(instr), 32'(NOP_I));
    step(2);
    check("t4_nop_req", 32'(bus.mem_req), 1);
    check("t4_nop_addr", 32'(bus.mem_addr), 0);
    reset = 1'b0;
    load(0, ei(2, 0, 1, 20));
    load(1, er(1, 1, 2, 0));
    load(2, ei(1, 0, 0, 9));
    load(3, er(0, 1, 3, 0));
    load(4, HALT_I);
    load(20, 21'h0FFFFF);
    release_reset();
    step(6);
    check("t4_lw", 32'(dest), 32'h0FFFFF);
    step(4);
    check("t4_add_wrap", 32'(dest), 32'h1FFFFE);
    step(4);
    check("t4_r0_dest", 32'(dest), 9);
    step(4);
    check("t4_r0_reads0", 32'(dest), 32'h0FFFFF);
    wait_halt("t4_halt", 10);
    reset = 1'b0;
    wait_n = 2;
    load(0, ei(1, 0, 1, 5));
    load(1, ei(2, 0, 4, 10));
    load(10, 21'd7);
    release_reset();
    k = 0;
    while (!(bus.mem_req && !bus.mem_we && bus.mem_addr == 10) && k < 100) begin
      step(1);
      k++;
    end
    check("t5_reach_mem", 32'(bus.mem_req && bus.mem_addr == 10), 1);
    check("t5_pre_dest", 32'(dest), 5);
    check("t5_in_wait", 32'(bus.mem_ready), 0);
    reset = 1'b0;
    #1;
    check("t5_rst_req", 32'(bus.mem_req), 0);
    check("t5_rst_pc", 32'(pc), 0);
    check("t5_rst_dest", 32'(dest), 0);
    load(0, er(4, 0, 5, 0));
    load(1, HALT_I);
    wait_n = 0;
    step(1);
    check("t5_rst_req_hold", 32'(bus.mem_req), 0);
    release_reset();
    step(1);
    check("t5_resume_req", 32'(bus.mem_req), 1);
    check("t5_resume_addr", 32'(bus.mem_addr), 0);
    step(4);
    check("t5_r4_unwritten", 32'(dest), 0);
    wait_halt("t5_halt", 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
